// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its buffer.
package fetch_stage_pkg;

    typedef logic [31:0] instruction_type;

    localparam logic [31:0]     DEFAULT_RESET_PC = 32'h0000_0000;
    localparam instruction_type NOP_INSTRUCTION  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     pc;
        instruction_type instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundles the instruction-memory port, the redirect input and the decode handshake.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            imem_req;
    logic [31:0]     imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [31:0]     redirect_pc;
    // Decode handshake: an entry transfers on a rising edge where id_valid && id_ready
    // && !redirect; while id_valid && !id_ready the payload is held unchanged.
    logic            id_valid;
    logic            id_ready;
    instruction_type id_instruction;
    logic [31:0]     id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instruction, id_pc,
        input  imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instruction, id_pc,
        output imem_rdata, redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_stage_buffer.sv
// Two-entry synchronous FIFO of {pc, instruction}; the head is always entry 0.
module fetch_buffer
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output logic [1:0]   count_o,
    output logic         head_valid_o,
    output fetch_entry_t head_o
);

    logic [1:0]   count_q, count_d;
    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;

    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (clear_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = push_entry_i;
                    end else begin
                        e0_d = push_entry_i;
                    end
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) e0_d = push_entry_i;
                    else                 e1_d = push_entry_i;
                    count_d = count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_o       = e0_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues word reads to a 1-cycle-latency memory and
// queues returned instructions for decode, flushing on redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         inflight_q, inflight_d;
    logic         drop_q, drop_d;

    logic         pop, push, issue;
    logic [31:0]  target, req_addr;
    logic [2:0]   credit_used;
    logic [1:0]   count;
    logic         head_valid;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    always_comb begin
        target      = word_align(bus.redirect_pc);
        pop         = head_valid && bus.id_ready && !bus.redirect;
        push        = inflight_q && !drop_q && !bus.redirect;
        // Slots already promised: queued entries plus the response still in flight.
        credit_used = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = bus.redirect || (credit_used < 3'(BUF_DEPTH));
        req_addr    = bus.redirect ? target : pc_q;
        pc_d        = issue ? req_addr + 32'd4 : pc_q;
        req_pc_d    = issue ? req_addr : req_pc_q;
        inflight_d  = issue;
        // A redirect always launches its own request, so nothing in flight is left stale.
        drop_d      = 1'b0;
        push_entry  = '{pc: req_pc_q, instr: bus.imem_rdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_buffer u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .clear_i      (bus.redirect),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    assign bus.imem_req       = !rst && issue;
    assign bus.imem_addr      = rst ? RESET_PC : req_addr;
    assign bus.id_valid       = head_valid;
    assign bus.id_instruction = head.instr;
    assign bus.id_pc          = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed reset/stream/stall/redirect vectors,
// then a randomized id_ready phase with occasional redirects.
module tb_fetch_stage;

    logic clk;
    logic rst;
    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: word(a) = a | 0x13, returned the cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= bus.imem_addr | 32'h13;
        else              bus.imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted entry is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && bus.id_valid && bus.id_ready && !bus.redirect) begin
            accepted++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_accept: got pc %08h expected none", bus.id_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.id_pc !== e || bus.id_instruction !== (e | 32'h13)) begin
                    errors++;
                    $display("FAIL accept: got pc %08h instr %08h expected pc %08h instr %08h",
                             bus.id_pc, bus.id_instruction, e, e | 32'h13);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && dut.u_buf.push_i && !dut.u_buf.pop_i && !dut.u_buf.clear_i
            && dut.u_buf.count_q == 2'd2) begin
            errors++;
            $display("FAIL overflow: got push into full queue expected no push");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        rst             = r;
        bus.id_ready    = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
    endtask

    task automatic topup();
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_exp);
            next_exp = next_exp + 32'd4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        check("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        check("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
        check("rst_id_instr", bus.id_instruction, 32'h0);
        check("rst_id_pc", bus.id_pc, 32'h0);

        // Streaming with id_ready high from the start.
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        drive(1'b0, 1'b1, 1'b0, 32'h0); #1;
        check("c0_req", {31'b0, bus.imem_req}, 32'd1);
        check("c0_addr", bus.imem_addr, 32'h0);
        check("c0_valid", {31'b0, bus.id_valid}, 32'd0);
        tick();
        check("c1_valid", {31'b0, bus.id_valid}, 32'd0);
        check("c1_addr", bus.imem_addr, 32'h4);
        tick();
        check("c2_valid", {31'b0, bus.id_valid}, 32'd1);
        check("c2_pc", bus.id_pc, 32'h0);
        repeat (3) tick();
        check("stream_pc12", bus.id_pc, 32'hC);

        // Reset during streaming with redirect also asserted.
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h300); #1;
        check("midrst_req", {31'b0, bus.imem_req}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check("postrst_valid", {31'b0, bus.id_valid}, 32'd0);
        check("postrst_pc", bus.id_pc, 32'h0);
        check("postrst_instr", bus.id_instruction, 32'h0);
        check("postrst_req", {31'b0, bus.imem_req}, 32'd1);
        check("postrst_addr", bus.imem_addr, 32'h0);
        check("stream_drained", exp_q.size(), 32'd0);

        // Stall right after the first valid: only PC 4 is fetched beyond the head.
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        tick();
        tick();
        check("stall_valid", {31'b0, bus.id_valid}, 32'd1);
        check("stall_pc", bus.id_pc, 32'h0);
        check("stall_noreq_c2", {31'b0, bus.imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_hold_pc", bus.id_pc, 32'h0);
            check("stall_noreq", {31'b0, bus.imem_req}, 32'd0);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0); #1;
        check("resume_req", {31'b0, bus.imem_req}, 32'd1);
        check("resume_addr", bus.imem_addr, 32'h8);
        tick();
        check("resume_pc4", bus.id_pc, 32'h4);

        // Redirect to 0x100 while PC 8 is at the head.
        tick();
        check("redir_head8", bus.id_pc, 32'h8);
        check("redir_sb_empty", exp_q.size(), 32'd0);
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        drive(1'b0, 1'b1, 1'b1, 32'h100); #1;
        check("redir_req", {31'b0, bus.imem_req}, 32'd1);
        check("redir_addr", bus.imem_addr, 32'h100);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0); #1;
        check("redir_r1_valid", {31'b0, bus.id_valid}, 32'd0);
        tick();
        check("redir_r2_valid", {31'b0, bus.id_valid}, 32'd1);
        check("redir_r2_pc", bus.id_pc, 32'h100);
        tick();
        check("redir_r3_pc", bus.id_pc, 32'h104);

        // Stall until the queue is full, then redirect to an unaligned target.
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(1'b0, 1'b0, 1'b0, 32'h0); #1;
        end
        check("full_valid", {31'b0, bus.id_valid}, 32'd1);
        check("full_pc", bus.id_pc, 32'h108);
        check("full_noreq", {31'b0, bus.imem_req}, 32'd0);
        tick();
        exp_q.delete();
        next_exp = 32'h200;
        topup();
        drive(1'b0, 1'b0, 1'b1, 32'h203); #1;
        check("full_redir_addr", bus.imem_addr, 32'h200);
        check("full_redir_req", {31'b0, bus.imem_req}, 32'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0); #1;
        check("full_r1_valid", {31'b0, bus.id_valid}, 32'd0);
        tick();
        check("full_r2_valid", {31'b0, bus.id_valid}, 32'd1);
        check("full_r2_pc", bus.id_pc, 32'h200);

        // Random id_ready with occasional redirects; the scoreboard follows the PC.
        begin
            int acc_start;
            acc_start = accepted;
            for (int i = 0; i < 1000; i++) begin
                logic        rdy;
                logic        rd;
                logic [31:0] rpc;
                tick();
                rdy = 1'($urandom_range(0, 1));
                rd  = ($urandom_range(0, 49) == 0);
                rpc = $urandom;
                topup();
                if (rd) begin
                    exp_q.delete();
                    next_exp = {rpc[31:2], 2'b00};
                    topup();
                end
                drive(1'b0, rdy, rd, rpc); #1;
                if (rd) check("rand_redir_addr", bus.imem_addr, {rpc[31:2], 2'b00});
            end
            tick();
            drive(1'b0, 1'b0, 1'b0, 32'h0); #1;
            checks++;
            if (accepted - acc_start < 200) begin
                errors++;
                $display("FAIL rand_throughput: got %0d accepts expected at least 200",
                         accepted - acc_start);
            end
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
